// File: rtl/booth_step_counter_pkg.sv
// Shared definitions for the radix-8 Booth step sequencer.
//   state_e       : sequencer FSM states (IDLE, RUN)
//   MULT_BITS     : multiplier operand width the default sizing assumes
//   DEFAULT_WIDTH : default step-counter width, ceil(MULT_BITS/3)
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MULT_BITS     = 12;
    localparam int DEFAULT_WIDTH = (MULT_BITS + 2) / 3;

endpackage

// File: rtl/booth_step_counter_if.sv
// Control/status bundle between the multiplier control FSM (master) and the
// step sequencer (slave).
//   clear, start, max_val, en        : master -> slave
//   count, busy, last, done, pass_cnt : slave -> master
//   state                             : slave -> master, FSM state for debug
// Handshake: a run is requested by holding start high for one cycle while
// busy is low; the request is accepted on that edge and busy rises after it.
// While busy is high, every cycle with en high is one step; the step taken
// while last is high is terminal and produces a one-cycle done pulse.
interface booth_step_counter_if
    import booth_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int PASS_W = 8
);
    logic              clear;
    logic              start;
    logic [WIDTH-1:0]  max_val;
    logic              en;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              last;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;
    state_e            state;

    modport master (
        output clear, start, max_val, en,
        input  count, busy, last, done, pass_cnt, state
    );

    modport slave (
        input  clear, start, max_val, en,
        output count, busy, last, done, pass_cnt, state
    );
endinterface

// File: rtl/booth_step_counter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to zero (wins over inc)
//   inc        : add one, holding at all-ones once reached
//   value      : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);
    localparam logic [W-1:0] ONE = 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + ONE;
        end
    end
endmodule

// File: rtl/booth_step_counter.sv
// Iteration sequencer for the radix-8 Booth multiplier datapath. Counts
// partial-product steps from 0 to a terminal value latched at start, flags
// the terminal step (last) and pulses done on the cycle after it.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of booth_step_counter_if (see interface header)
// AUTO_RESTART=1 keeps the sequencer in RUN after each terminal step,
// restarting at 0 with the same terminal value.
module booth_step_counter
    import booth_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PASS_W       = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    booth_step_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        max_d    = max_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_inc = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // en is deliberately ignored here, even alongside start.
                    if (bus.start) begin
                        state_d = RUN;
                        count_d = '0;
                        max_d   = bus.max_val;
                        busy_d  = 1'b1;
                    end
                end
                RUN: begin
                    // start is ignored in RUN, terminal cycle included.
                    if (bus.en) begin
                        if (count_q == max_q) begin
                            done_d   = 1'b1;
                            count_d  = '0;
                            pass_inc = 1'b1;
                            if (!AUTO_RESTART) begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(PASS_W)) u_pass_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .inc   (pass_inc),
        .value (bus.pass_cnt)
    );

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
    assign bus.last  = busy_q && (count_q == max_q);
endmodule

// File: doc/booth_step_counter.md
Name: booth_step_counter

Overview:
Parametrised iteration sequencer for the radix-8 Booth multiplier datapath. It counts partial-product steps from 0 up to a terminal value latched at start, and signals the final step and completion. Unlike the fixed-width, fixed-max step counter, it has a start/busy/done handshake, a run-time programmable terminal count, synchronous clear, optional auto-restart, and a completed-pass counter. Sits between the multiplier control FSM and the shift/accumulate datapath.

Parameters:
WIDTH, 4, width of count and max_val
PASS_W, 8, width of pass_cnt
AUTO_RESTART, 0, 1 = after terminal step restart at 0 and stay busy; 0 = return to idle

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous abort: return to IDLE, count 0, no done
start  input  1  begin a run; latches max_val; ignored while busy
max_val  input  WIDTH  terminal count, sampled only on accepted start
en  input  1  advance one step (valid only while busy)
count  output  WIDTH  current step index
busy  output  1  high in RUN
last  output  1  combinational: busy && count == latched max
done  output  1  one-cycle pulse on the cycle after the terminal step is taken
pass_cnt  output  PASS_W  number of completed runs since reset/clear, saturating

Behaviour:
- Reset (async, active-high): state IDLE, count 0, max_lat 0, busy 0, done 0, pass_cnt 0; last 0 by construction.
- States: IDLE, RUN. Registered outputs: count, busy, done, pass_cnt.
- Priority each clock edge: clear > start/en handling. done defaults to 0 every cycle (pulse only).
- IDLE: start=1 -> RUN, count<=0, max_lat<=max_val, busy<=1. en ignored in IDLE. count holds its value otherwise.
- RUN, en=0: hold everything.
- RUN, en=1, count<max_lat: count<=count+1.
- RUN, en=1, count==max_lat (terminal step): done<=1, count<=0, pass_cnt<=pass_cnt+1 saturating at all-ones; AUTO_RESTART=0 -> IDLE, busy<=0; AUTO_RESTART=1 -> stay RUN, max_lat retained.
- start while RUN: ignored (no relatch, no count change), including on the terminal cycle.
- start and en both high in IDLE: start accepted, en ignored that cycle (count=0 after edge).
- max_val=0: run is one step; first en in RUN gives done next cycle; last high for whole run.
- max_val=all-ones: count reaches 2^WIDTH-1, no wrap past it; terminal step returns count to 0.
- clear in RUN: IDLE, count 0, busy 0, no done, pass_cnt 0. clear in IDLE: same.
- Reset mid-run: immediate async return to reset values; done never asserted.
- Latency: start to busy = 1 cycle; terminal en to done = 1 cycle; done coincides with busy=0 (AUTO_RESTART=0).
- No combinational path from inputs to registered outputs; last depends on count and max_lat only.

Decomposition:
- Shared package (booth_pkg): state enum {IDLE, RUN}; default WIDTH constant for radix-8 step count (ceil(N/3)).
- One natural sub-module: sat_counter (PASS_W-wide saturating incrementer with sync clear), instantiated for pass_cnt. FSM and step counter stay in the top.

Test Plan:
- Reset: assert reset mid-cycle with count=2 -> count, busy, done, pass_cnt = 0 immediately, without a clock edge.
- Basic run: max_val=3, start, en held high 4 cycles -> count 0,1,2,3; last high at count 3; done pulses once; busy falls with done; pass_cnt=1.
- Stall and ignore: max_val=5, en toggled 1/0 alternately, start pulsed mid-run with max_val=1 -> count advances only on en cycles, terminal at 5, max_lat stays 5.
- Edge values: max_val=0 -> single en gives done, last high whole run; max_val=15 (WIDTH=4) -> 16 steps, count returns to 0, no overflow.
- AUTO_RESTART=1, max_val=2, en held high 9 cycles -> three done pulses, busy stays 1, pass_cnt=3, count cycles 0,1,2.
- Clear at count=2 of max 3 -> next cycle IDLE, count 0, no done, pass_cnt 0; a subsequent start runs normally.
